// File: rtl/tx_frame_sched.sv
// Transmit frame scheduler: reads a buffered frame, prepends preamble/SFD,
// streams it to the PHY and enforces the inter-frame gap.
module tx_frame_sched #(
   parameter int IFG     = 12,
   parameter int MAX_LEN = 1536
) (
   input  logic        txc,
   input  logic        RST,
   input  logic        New_Frame,
   input  logic [10:0] FIFO_Data_Num,
   input  logic [7:0]  RAM_Dataout,
   output logic        RD_EN,
   output logic [7:0]  txd,
   output logic        txen,
   output logic        Busy,
   output logic [15:0] Frame_Cnt,
   output logic [7:0]  Err_Cnt
);

   typedef enum logic [2:0] {IDLE, LEN, PRE, SFD, DATA, DISCARD, GAP} state_t;

   localparam logic [10:0] IFG_M1 = 11'(IFG - 1);
   localparam logic [10:0] MAX_L  = 11'(MAX_LEN);

   state_t      state_reg, state_next;
   logic [10:0] cnt_reg, cnt_next;
   logic [10:0] len_reg, len_next;
   logic        pending_reg, pending_next;
   logic [1:0]  vld_reg;
   logic [15:0] frame_cnt_reg;
   logic [7:0]  err_cnt_reg;
   logic        frame_inc, err_len, err_disc, err_dup;
   logic [8:0]  err_sum;
   logic [10:0] len_m1;
   logic [11:0] cnt_plus3;
   logic        gap_done;

   assign len_m1    = len_reg - 11'd1;
   assign cnt_plus3 = {1'b0, cnt_reg} + 12'd3;
   assign gap_done  = (state_reg == GAP) && (cnt_reg == IFG_M1);
   assign err_dup   = New_Frame && pending_reg;
   assign err_sum   = {1'b0, err_cnt_reg} + {8'd0, err_len} + {8'd0, err_disc} + {8'd0, err_dup};

   always_ff @(posedge txc or negedge RST) begin
      if (!RST) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         len_reg       <= '0;
         pending_reg   <= 1'b0;
         vld_reg       <= '0;
         frame_cnt_reg <= '0;
         err_cnt_reg   <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         len_reg       <= len_next;
         pending_reg   <= pending_next;
         vld_reg       <= {vld_reg[0], RD_EN};
         frame_cnt_reg <= frame_cnt_reg + {15'd0, frame_inc};
         err_cnt_reg   <= (err_sum > 9'd255) ? 8'd255 : err_sum[7:0];
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      len_next     = len_reg;
      pending_next = pending_reg;
      RD_EN        = 1'b0;
      txen         = 1'b0;
      txd          = 8'h00;
      frame_inc    = 1'b0;
      err_len      = 1'b0;
      err_disc     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (New_Frame || pending_reg) begin
               state_next   = LEN;
               pending_next = 1'b0;
            end
         end
         LEN: begin
            len_next = FIFO_Data_Num;
            cnt_next = '0;
            if (FIFO_Data_Num == 11'd0) begin
               err_len    = 1'b1;
               state_next = IDLE;
            end else if (FIFO_Data_Num > MAX_L) begin
               state_next = DISCARD;
            end else begin
               state_next = PRE;
            end
         end
         PRE: begin
            txen = 1'b1;
            txd  = 8'h55;
            // First read goes out two cycles before the first data slot.
            if (cnt_reg == 11'd6) begin
               RD_EN      = 1'b1;
               cnt_next   = '0;
               state_next = SFD;
            end else begin
               cnt_next = cnt_reg + 11'd1;
            end
         end
         SFD: begin
            txen       = 1'b1;
            txd        = 8'hD5;
            RD_EN      = (len_reg >= 11'd2);
            state_next = DATA;
         end
         DATA: begin
            txen  = 1'b1;
            txd   = RAM_Dataout;
            RD_EN = (cnt_plus3 <= {1'b0, len_reg});
            if (cnt_reg == len_m1) begin
               frame_inc  = 1'b1;
               cnt_next   = '0;
               state_next = GAP;
            end else begin
               cnt_next = cnt_reg + 11'd1;
            end
         end
         DISCARD: begin
            // Flush L bytes, then let the last read drain through the latency pipe.
            if (cnt_reg != len_reg) begin
               RD_EN    = 1'b1;
               cnt_next = cnt_reg + 11'd1;
            end else if (vld_reg == 2'b10) begin
               err_disc   = 1'b1;
               state_next = IDLE;
            end
         end
         GAP: begin
            if (gap_done) begin
               cnt_next   = '0;
               state_next = (New_Frame && !pending_reg) ? LEN : IDLE;
            end else begin
               cnt_next = cnt_reg + 11'd1;
            end
         end
         default: state_next = IDLE;
      endcase
      if (New_Frame && !pending_reg && state_reg != IDLE && !gap_done)
         pending_next = 1'b1;
   end

   assign Busy      = (state_reg != IDLE);
   assign Frame_Cnt = frame_cnt_reg;
   assign Err_Cnt   = err_cnt_reg;

endmodule

// File: tb/tb_tx_frame_sched.sv
// Randomized scoreboard bench for tx_frame_sched: a timeline model predicts
// every txen byte, RD_EN cycle and Busy interval from each New_Frame request.
module tb_tx_frame_sched;
   localparam int IFG     = 12;
   localparam int MAX_LEN = 1536;

   logic        txc = 1'b0;
   logic        RST = 1'b0;
   logic        New_Frame = 1'b0;
   logic [10:0] FIFO_Data_Num = '0;
   logic [7:0]  RAM_Dataout = '0;
   logic        RD_EN, txen, Busy;
   logic [7:0]  txd, Err_Cnt;
   logic [15:0] Frame_Cnt;

   tx_frame_sched #(.IFG(IFG), .MAX_LEN(MAX_LEN)) dut (
      .txc(txc), .RST(RST), .New_Frame(New_Frame), .FIFO_Data_Num(FIFO_Data_Num),
      .RAM_Dataout(RAM_Dataout), .RD_EN(RD_EN), .txd(txd), .txen(txen),
      .Busy(Busy), .Frame_Cnt(Frame_Cnt), .Err_Cnt(Err_Cnt)
   );

   always #5 txc = ~txc;

   typedef struct {int cyc; logic [7:0] d;} tx_t;
   typedef struct {int s; int e;} iv_t;
   typedef struct {int s; int l;} ls_t;

   tx_t        exp_tx[$];
   int         exp_rd[$];
   iv_t        exp_bsy[$];
   ls_t        len_sched[$];
   logic [7:0] buf_q[$];

   int cyc = 0;
   int n_cmp = 0, n_fail = 0;
   int f_t, f_s, f_e, m_frames, m_errs;
   bit f_gap;
   bit bsy_prev = 1'b0;

   initial forever @(posedge txc) cyc++;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   function automatic void model_reset();
      exp_tx.delete(); exp_rd.delete(); exp_bsy.delete();
      len_sched.delete(); buf_q.delete();
      f_t = -10; f_s = -10; f_e = -10; f_gap = 1'b0;
      m_frames = 0; m_errs = 0;
   endfunction

   function automatic void err_up();
      m_errs = (m_errs < 255) ? m_errs + 1 : 255;
   endfunction

   // Request at cycle t: reject if one is already pending, otherwise schedule
   // its LEN cycle and derive every observable event from the frame rules.
   function automatic void model_issue(int t, int L);
      int s, e, t0;
      tx_t x;
      logic [7:0] b;
      if (t >= f_t + 1 && t <= f_s - 1) begin
         err_up();
         return;
      end
      s = (t > f_e || (t == f_e && f_gap)) ? t + 1 : f_e + 2;
      f_t = t; f_s = s;
      len_sched.push_back('{s, L});
      if (L == 0) begin
         e = s; f_gap = 1'b0; err_up();
      end else if (L > MAX_LEN) begin
         for (int i = 1; i <= L; i++) begin
            exp_rd.push_back(s + i);
            buf_q.push_back(8'($urandom));
         end
         e = s + L + 2; f_gap = 1'b0; err_up();
      end else begin
         t0 = s + 1;
         for (int i = 0; i < 8; i++) begin
            x.cyc = t0 + i; x.d = (i == 7) ? 8'hD5 : 8'h55;
            exp_tx.push_back(x);
         end
         for (int i = 0; i < L; i++) begin
            b = 8'($urandom);
            buf_q.push_back(b);
            x.cyc = t0 + 8 + i; x.d = b;
            exp_tx.push_back(x);
            exp_rd.push_back(t0 + 6 + i);
         end
         e = t0 + 7 + L + IFG; f_gap = 1'b1;
         m_frames = (m_frames + 1) % 65536;
      end
      f_e = e;
      exp_bsy.push_back('{s, e});
   endfunction

   task automatic step(input bit nf, input int L);
      ls_t ls;
      @(posedge txc); #1;
      if (len_sched.size() > 0 && len_sched[0].s == cyc) begin
         ls = len_sched.pop_front();
         FIFO_Data_Num = 11'(ls.l);
      end else begin
         FIFO_Data_Num = 11'($urandom);
      end
      New_Frame = nf;
      if (nf) model_issue(cyc, L);
   endtask

   task automatic settle();
      int lim;
      lim = f_e + 3;
      while (cyc < lim) step(1'b0, 0);
      chk("frame_cnt", Frame_Cnt, m_frames);
      chk("err_cnt", Err_Cnt, m_errs);
      chk("tx_left", exp_tx.size(), 0);
      chk("rd_left", exp_rd.size(), 0);
      chk("busy_left", exp_bsy.size(), 0);
   endtask

   // Receive buffer: data for a read in cycle k is presented during cycle k+2.
   initial begin
      logic [7:0] stage_a;
      bit rd_seen;
      stage_a = 8'h00;
      forever begin
         @(negedge txc);
         rd_seen = RD_EN;
         @(posedge txc); #1;
         RAM_Dataout = stage_a;
         if (rd_seen && buf_q.size() > 0) stage_a = buf_q.pop_front();
         else stage_a = 8'($urandom);
      end
   end

   // Monitor: pops expectations whenever the DUT shows txen, RD_EN or Busy edges.
   initial begin
      tx_t e;
      iv_t iv;
      int c, bsy_end;
      bsy_end = 0;
      forever begin
         @(negedge txc);
         if (!RST) begin
            bsy_prev = 1'b0;
         end else begin
            if (txen) begin
               if (exp_tx.size() == 0) chk("txen", txen, 0);
               else begin
                  e = exp_tx.pop_front();
                  chk("txen_cycle", cyc, e.cyc);
                  chk("txd", txd, e.d);
               end
            end else begin
               chk("txd_idle", txd, 0);
               if (exp_tx.size() > 0 && exp_tx[0].cyc <= cyc) begin
                  e = exp_tx.pop_front();
                  chk("txen", txen, 1);
               end
            end
            if (RD_EN) begin
               if (exp_rd.size() == 0) chk("rd_en", RD_EN, 0);
               else begin
                  c = exp_rd.pop_front();
                  chk("rd_en_cycle", cyc, c);
               end
            end else if (exp_rd.size() > 0 && exp_rd[0] <= cyc) begin
               c = exp_rd.pop_front();
               chk("rd_en", RD_EN, 1);
            end
            if (Busy && !bsy_prev) begin
               if (exp_bsy.size() == 0) chk("busy", Busy, 0);
               else begin
                  iv = exp_bsy.pop_front();
                  chk("busy_rise", cyc, iv.s);
                  bsy_end = iv.e;
               end
            end else if (!Busy && bsy_prev) begin
               while (exp_bsy.size() > 0 && exp_bsy[0].s == bsy_end + 1) begin
                  iv = exp_bsy.pop_front();
                  bsy_end = iv.e;
               end
               chk("busy_fall", cyc, bsy_end + 1);
            end else if (!Busy && exp_bsy.size() > 0 && exp_bsy[0].s <= cyc) begin
               iv = exp_bsy.pop_front();
               chk("busy", Busy, 1);
            end
            bsy_prev = Busy;
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int tr, L;
      model_reset();
      repeat (3) @(posedge txc);
      @(negedge txc);
      chk("rst_txen", txen, 0);
      chk("rst_rd_en", RD_EN, 0);
      chk("rst_txd", txd, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_frame_cnt", Frame_Cnt, 0);
      chk("rst_err_cnt", Err_Cnt, 0);
      @(posedge txc); #1;
      RST = 1'b1;

      // single 64-byte frame requested at cycle 10
      while (cyc < 9) step(1'b0, 0);
      step(1'b1, 64);
      settle();

      // back-to-back pending frame, then a third request while pending
      step(1'b1, 64);
      repeat (40) step(1'b0, 0);
      step(1'b1, 60);
      repeat (5) step(1'b0, 0);
      step(1'b1, 10);
      settle();

      // zero length, oversize and length boundaries
      step(1'b1, 0);    settle();
      step(1'b1, 2000); settle();
      step(1'b1, 1536); settle();
      step(1'b1, 1537); settle();
      step(1'b1, 1);
      step(1'b1, 2);
      settle();

      // request arriving in the last GAP cycle
      step(1'b1, 5);
      while (cyc < f_e - 1) step(1'b0, 0);
      step(1'b1, 7);
      settle();

      // random traffic
      repeat (4000) begin
         if ($urandom_range(0, 39) == 0) begin
            case ($urandom_range(0, 19))
               0:       L = 0;
               1:       L = $urandom_range(1537, 1600);
               2:       L = $urandom_range(1, 3);
               default: L = $urandom_range(4, 120);
            endcase
            step(1'b1, L);
         end else begin
            step(1'b0, 0);
         end
      end
      settle();

      // reset during byte 30 of a 64-byte frame
      step(1'b1, 64);
      tr = cyc;
      while (cyc < tr + 39) step(1'b0, 0);
      @(posedge txc); #1;
      RST = 1'b0;
      model_reset();
      @(negedge txc);
      chk("mid_rst_txen", txen, 0);
      chk("mid_rst_rd_en", RD_EN, 0);
      chk("mid_rst_txd", txd, 0);
      chk("mid_rst_busy", Busy, 0);
      chk("mid_rst_frame_cnt", Frame_Cnt, 0);
      chk("mid_rst_err_cnt", Err_Cnt, 0);
      repeat (2) @(posedge txc);
      #1;
      RST = 1'b1;
      step(1'b1, 64);
      settle();

      // 300 zero-length rejects saturate the error counter
      repeat (300) begin
         step(1'b1, 0);
         step(1'b0, 0);
         step(1'b0, 0);
      end
      settle();
      chk("err_sat", Err_Cnt, 255);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end
endmodule
